mac_dot_seq: RTL and testbench

Operand sequencer that drives a single-cycle registered multiply-accumulate unit (`p <= a*b + c` on `ce`, cleared by `sclr`) to compute K-term dot products plus bias. It accepts operand pairs on a valid/ready stream, issues them to the MAC with the correct `c` feedback, and returns each finished sum on a valid/ready result port. It sits between the feature/weight fetch logic and the MAC in the convolution datapath.

---
 rtl/mac_dot_seq.sv | 109 ++++++++++
 tb/tb_mac_dot_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_seq.sv
// Operand sequencer for a registered multiply-accumulate unit: streams K operand
// pairs per dot product into the MAC, seeds the first term with bias, and returns each sum.
module mac_dot_seq #(
    parameter int N = 16,
    parameter int K = 9
) (
    input  logic         clk,
    input  logic         sclr,
    input  logic [N-1:0] bias,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [N-1:0] s_a,
    input  logic [N-1:0] s_b,
    output logic         mac_sclr,
    output logic         mac_ce,
    output logic [N-1:0] mac_a,
    output logic [N-1:0] mac_b,
    output logic [N-1:0] mac_c,
    input  logic [N-1:0] mac_p,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N-1:0] m_data
);

    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          m_valid_q, m_valid_d;
    logic [N-1:0]  m_data_q, m_data_d;

    logic handshake;
    logic slot_free;
    logic load_result;

    // The MAC is cleared by the same reset edge that clears the sequencer.
    assign mac_sclr = sclr;
    assign s_ready  = (state_q == ST_ACC) && !sclr;
    assign handshake = s_valid && s_ready;
    assign mac_ce   = handshake;
    assign mac_a    = s_a;
    assign mac_b    = s_b;
    // Term 0 starts from bias; later terms accumulate onto the MAC output.
    assign mac_c    = (cnt_q == '0) ? bias : mac_p;

    assign slot_free   = !m_valid_q || m_ready;
    assign load_result = (state_q == ST_DONE) && slot_free;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ACC: begin
                if (handshake) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_DONE: begin
                if (slot_free) begin
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
                cnt_d   = '0;
            end
        endcase
    end

    // A load on the same edge as a consume keeps the slot full with the new sum.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (m_ready) begin
            m_valid_d = 1'b0;
        end
        if (load_result) begin
            m_valid_d = 1'b1;
            m_data_d  = mac_p;
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q   <= ST_ACC;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq: K=3 instance under directed and random traffic against a
// sum-of-products scoreboard, plus a K=1 instance for the single-term boundary.
module tb_mac_dot_seq;

    localparam int N  = 16;
    localparam int K3 = 3;

    logic         clk = 1'b0;
    logic         sclr;
    logic [N-1:0] bias;
    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] s_a, s_b;
    logic         mac_sclr, mac_ce;
    logic [N-1:0] mac_a, mac_b, mac_c;
    logic [N-1:0] mac_p;
    logic         m_valid;
    logic         m_ready;
    logic [N-1:0] m_data;

    logic         k1_s_valid, k1_s_ready;
    logic [N-1:0] k1_bias, k1_s_a, k1_s_b;
    logic         k1_mac_sclr, k1_mac_ce;
    logic [N-1:0] k1_mac_a, k1_mac_b, k1_mac_c, k1_mac_p;
    logic         k1_m_valid, k1_m_ready;
    logic [N-1:0] k1_m_data;

    logic m_ready_dir, rand_mode, rnd_ready;
    assign m_ready = rand_mode ? rnd_ready : m_ready_dir;

    int n_checks = 0;
    int n_errors = 0;
    int ce_count = 0;
    int n_results = 0;

    always #5 clk = ~clk;

    mac_dot_seq #(.N(N), .K(K3)) dut (
        .clk(clk), .sclr(sclr), .bias(bias),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .mac_sclr(mac_sclr), .mac_ce(mac_ce), .mac_a(mac_a), .mac_b(mac_b),
        .mac_c(mac_c), .mac_p(mac_p),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    mac_dot_seq #(.N(N), .K(1)) dut_k1 (
        .clk(clk), .sclr(sclr), .bias(k1_bias),
        .s_valid(k1_s_valid), .s_ready(k1_s_ready), .s_a(k1_s_a), .s_b(k1_s_b),
        .mac_sclr(k1_mac_sclr), .mac_ce(k1_mac_ce), .mac_a(k1_mac_a), .mac_b(k1_mac_b),
        .mac_c(k1_mac_c), .mac_p(k1_mac_p),
        .m_valid(k1_m_valid), .m_ready(k1_m_ready), .m_data(k1_m_data)
    );

    // Integer-mode MAC units the sequencers drive.
    always @(posedge clk) begin
        if (mac_sclr) mac_p <= '0;
        else if (mac_ce) mac_p <= mac_a * mac_b + mac_c;
        if (k1_mac_sclr) k1_mac_p <= '0;
        else if (k1_mac_ce) k1_mac_p <= k1_mac_a * k1_mac_b + k1_mac_c;
    end

    always @(posedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: each vector is bias + sum of a*b over K accepted pairs, mod 2^N.
    logic [N-1:0] exp_q[$];
    logic [31:0]  acc_ref;
    int           n_terms = 0;
    logic         hold_prev = 1'b0;
    logic [N-1:0] prev_data;

    always @(negedge clk) begin
        if (sclr) begin
            n_terms   = 0;
            hold_prev = 1'b0;
            exp_q.delete();
        end else begin
            if (mac_ce) ce_count++;
            if (s_valid && s_ready) begin
                if (n_terms == 0) acc_ref = 32'(bias);
                acc_ref = acc_ref + 32'(s_a) * 32'(s_b);
                n_terms++;
                if (n_terms == K3) begin
                    exp_q.push_back(acc_ref[N-1:0]);
                    n_terms = 0;
                end
            end
            if (m_valid && m_ready) begin
                n_results++;
                if (exp_q.size() == 0) check("unexpected_result", 32'(m_data), 32'hDEAD_BEEF);
                else check("result", 32'(m_data), 32'(exp_q.pop_front()));
            end
            if (hold_prev) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(prev_data));
            end
            hold_prev = m_valid && !m_ready;
            prev_data = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
        s_a = a;
        s_b = b;
        s_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) begin
                tick();
                return;
            end
            tick();
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_a = 16'($urandom);
        s_b = 16'($urandom);
        repeat (n) tick();
    endtask

    task automatic wait_result(output logic [N-1:0] d);
        d = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_valid) begin
                d = m_data;
                return;
            end
        end
        check("result_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] d;
    int vectors_done;

    initial begin
        sclr = 1'b1; bias = '0; s_valid = 1'b0; s_a = '0; s_b = '0;
        m_ready_dir = 1'b1; rand_mode = 1'b0;
        k1_s_valid = 1'b0; k1_bias = '0; k1_s_a = '0; k1_s_b = '0; k1_m_ready = 1'b1;
        vectors_done = 0;

        @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_mac_sclr", 32'(mac_sclr), 32'd1);
        check("rst_k1_s_ready", 32'(k1_s_ready), 32'd0);
        tick();
        sclr = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", 32'(s_ready), 32'd1);
        check("post_rst_m_valid", 32'(m_valid), 32'd0);
        tick();

        // Basic vector: 10 + 6 + 20 + 7 = 43, one DONE cycle with s_ready low.
        bias = 16'd10;
        send(16'd2, 16'd3);
        send(16'd4, 16'd5);
        send(16'd1, 16'd7);
        s_valid = 1'b0;
        @(negedge clk);
        check("basic_done_s_ready", 32'(s_ready), 32'd0);
        check("basic_done_m_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("basic_m_valid", 32'(m_valid), 32'd1);
        check("basic_m_data", 32'(m_data), 32'd43);
        check("basic_s_ready_back", 32'(s_ready), 32'd1);
        tick();
        vectors_done++;

        // Wrap: 0x100*0x100 = 0x10000 wraps to 0.
        bias = 16'd0;
        send(16'h0100, 16'h0100);
        send(16'h0001, 16'h0005);
        send(16'h0000, 16'h0000);
        s_valid = 1'b0;
        wait_result(d);
        check("wrap", 32'(d), 32'h5);
        tick();
        vectors_done++;

        // Back-pressure: v1 = 18 sits in the slot, v2 = 22 stalls in DONE.
        m_ready_dir = 1'b0;
        bias = 16'd4;
        send(16'd1, 16'd1); send(16'd2, 16'd2); send(16'd3, 16'd3);
        bias = 16'd7;
        send(16'd2, 16'd3); send(16'd1, 16'd1); send(16'd4, 16'd2);
        bias = 16'd2;
        s_a = 16'd5; s_b = 16'd6; s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_s_ready", 32'(s_ready), 32'd0);
            check("bp_m_valid", 32'(m_valid), 32'd1);
            check("bp_m_data", 32'(m_data), 32'd18);
        end
        tick();
        m_ready_dir = 1'b1;
        @(negedge clk);
        check("bp_v1_out", 32'(m_data), 32'd18);
        @(negedge clk);
        check("bp_reload_valid", 32'(m_valid), 32'd1);
        check("bp_reload_data", 32'(m_data), 32'd22);
        tick();
        send(16'd5, 16'd6);
        send(16'd5, 16'd6);
        s_valid = 1'b0;
        wait_result(d);
        check("bp_v3", 32'(d), 32'd92);
        tick();
        vectors_done += 3;

        // Gapped input: 1 + 3*(1*1) = 4 with exactly three MAC enables.
        begin
            int ce_base;
            ce_base = ce_count;
            bias = 16'd1;
            for (int t = 0; t < K3; t++) begin
                idle($urandom_range(0, 3));
                send(16'd1, 16'd1);
            end
            idle(0);
            wait_result(d);
            check("gap_result", 32'(d), 32'd4);
            check("gap_ce_count", 32'(ce_count - ce_base), 32'(K3));
            tick();
            vectors_done++;
        end

        // Mid-vector reset discards two terms; the next pair is term 0.
        bias = 16'd0;
        send(16'd9, 16'd9);
        send(16'd8, 16'd8);
        s_valid = 1'b0;
        sclr = 1'b1;
        @(negedge clk);
        check("mid_rst_s_ready", 32'(s_ready), 32'd0);
        check("mid_rst_mac_sclr", 32'(mac_sclr), 32'd1);
        tick();
        sclr = 1'b0;
        @(negedge clk);
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        tick();
        send(16'd3, 16'd3); send(16'd1, 16'd1); send(16'd2, 16'd2);
        s_valid = 1'b0;
        wait_result(d);
        check("mid_rst_result", 32'(d), 32'd14);
        tick();
        vectors_done++;

        // Random vectors with random gaps and random downstream stalls.
        rand_mode = 1'b1;
        for (int v = 0; v < 25; v++) begin
            bias = 16'($urandom);
            for (int t = 0; t < K3; t++) begin
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                send(16'($urandom), 16'($urandom));
            end
            vectors_done++;
        end
        idle(0);
        rand_mode = 1'b0;
        m_ready_dir = 1'b1;
        repeat (20) tick();
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("result_count", 32'(n_results), 32'(vectors_done));

        // K=1: each pair is its own vector, one result every two cycles.
        k1_bias = 16'd5;
        k1_s_a = 16'd1; k1_s_b = 16'd2; k1_s_valid = 1'b1;
        @(negedge clk);
        check("k1_ready", 32'(k1_s_ready), 32'd1);
        tick();
        k1_s_a = 16'd3; k1_s_b = 16'd4;
        @(negedge clk);
        check("k1_done_ready", 32'(k1_s_ready), 32'd0);
        tick();
        @(negedge clk);
        check("k1_first_valid", 32'(k1_m_valid), 32'd1);
        check("k1_first_data", 32'(k1_m_data), 32'd7);
        check("k1_ready_again", 32'(k1_s_ready), 32'd1);
        tick();
        k1_s_valid = 1'b0;
        @(negedge clk);
        check("k1_gap_valid", 32'(k1_m_valid), 32'd0);
        tick();
        @(negedge clk);
        check("k1_second_valid", 32'(k1_m_valid), 32'd1);
        check("k1_second_data", 32'(k1_m_data), 32'd17);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
